// File: rtl/pacman_pkg.sv
// Shared definitions for the Pac-Man sprite pipeline: direction codes,
// frame-sequencer state encoding and sprite geometry.
package pacman_pkg;

    // Direction codes as seen by the bitmap ROM
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    // Sprite bounding box edge length in pixels
    localparam int SPRITE_SIZE = 16;

    // Beam / position coordinate width
    localparam int COORD_W = 9;

    // Per-frame update sequence
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TURN  = 2'd1,
        ST_CHECK = 2'd2,
        ST_MOVE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/sprite_window.sv
// Combinational hit test of the beam position against a 16x16 sprite box.
// Differences are taken mod 2^9, so pixels left of / above the box wrap to
// large values and fall outside; the box itself never wraps on screen.
module sprite_window
    import pacman_pkg::*;
(
    input  logic [COORD_W-1:0] hpos,
    input  logic [COORD_W-1:0] vpos,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    output logic [3:0]         dx,
    output logic [3:0]         dy,
    output logic               active
);

    logic [COORD_W-1:0] diff_x;
    logic [COORD_W-1:0] diff_y;

    // Offset of the beam from the sprite corner and the inside-box test
    always_comb begin
        diff_x = hpos - pos_x;
        diff_y = vpos - pos_y;
        dx     = diff_x[3:0];
        dy     = diff_y[3:0];
        active = (diff_x < COORD_W'(SPRITE_SIZE)) && (diff_y < COORD_W'(SPRITE_SIZE));
    end

endmodule

// File: rtl/pacman_sprite_sequencer.sv
// Frame-level Pac-Man sprite controller: once per frame applies a buffered
// joystick turn, consults the maze for blocking, moves the sprite one pixel
// and steps the chomp animation; every cycle it produces registered
// bitmap-ROM addressing for the scan-out beam.
module pacman_sprite_sequencer
    import pacman_pkg::*;
#(
    parameter int ANIM_PERIOD = 8,
    parameter int START_X     = 112,
    parameter int START_Y     = 184,
    parameter int X_WRAP      = 256,
    parameter int Y_MAX       = 224
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               vsync,
    input  logic [COORD_W-1:0] hpos,
    input  logic [COORD_W-1:0] vpos,
    input  logic               enable,
    input  logic [1:0]         dirReq,
    input  logic               dirReqValid,
    input  logic               blocked,
    output logic [1:0]         direction,
    output logic               animState,
    output logic [3:0]         yin,
    output logic [3:0]         xin,
    output logic               spriteActive,
    output logic [COORD_W-1:0] posX,
    output logic [COORD_W-1:0] posY,
    output logic               frameDone
);

    // A period of 1 still needs a one-bit counter that sits at zero
    localparam int                 CNT_W     = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
    localparam logic [CNT_W-1:0]   ANIM_LAST = CNT_W'(ANIM_PERIOD - 1);
    localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(X_WRAP - 1);
    localparam logic [COORD_W-1:0] Y_LIMIT   = COORD_W'(Y_MAX);
    localparam logic [COORD_W-1:0] X_RESET   = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] Y_RESET   = COORD_W'(START_Y);

    // Sequencer state
    seq_state_e         state_q, state_d;
    logic [1:0]         dir_q, dir_d;
    logic [1:0]         prev_dir_q, prev_dir_d;
    logic               turned_q, turned_d;
    logic               no_move_q, no_move_d;
    logic [COORD_W-1:0] pos_x_q, pos_x_d;
    logic [COORD_W-1:0] pos_y_q, pos_y_d;
    logic               anim_q, anim_d;
    logic [CNT_W-1:0]   anim_cnt_q, anim_cnt_d;
    logic               frame_done_q, frame_done_d;

    // Pending turn buffer
    logic               pend_valid_q, pend_valid_d;
    logic [1:0]         pend_dir_q, pend_dir_d;
    logic               pend_clr;

    // Scan addressing
    logic               active_q, active_d;
    logic [3:0]         xin_q, xin_d;
    logic [3:0]         yin_q, yin_d;
    logic [3:0]         win_dx;
    logic [3:0]         win_dy;
    logic               win_active;

    // Candidate results of a one-pixel move and one animation step
    logic [COORD_W-1:0] step_x;
    logic [COORD_W-1:0] step_y;
    logic [CNT_W-1:0]   step_cnt;
    logic               step_anim;

    // Next position in the current direction (tunnel wrap on x, clamp on y)
    // and the next chomp-animation counter/phase
    always_comb begin
        step_x = pos_x_q;
        step_y = pos_y_q;
        case (dir_q)
            DIR_UP:    step_y = (pos_y_q == '0) ? '0 : pos_y_q - COORD_W'(1);
            DIR_LEFT:  step_x = (pos_x_q == '0) ? X_LAST : pos_x_q - COORD_W'(1);
            DIR_DOWN:  step_y = (pos_y_q >= Y_LIMIT) ? Y_LIMIT : pos_y_q + COORD_W'(1);
            default:   step_x = (pos_x_q >= X_LAST) ? '0 : pos_x_q + COORD_W'(1);
        endcase
        if (anim_cnt_q == ANIM_LAST) begin
            step_cnt  = '0;
            step_anim = ~anim_q;
        end else begin
            step_cnt  = anim_cnt_q + CNT_W'(1);
            step_anim = anim_q;
        end
    end

    // Frame update sequence: IDLE -> TURN -> CHECK -> MOVE -> IDLE
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        prev_dir_d   = prev_dir_q;
        turned_d     = turned_q;
        no_move_d    = no_move_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        anim_d       = anim_q;
        anim_cnt_d   = anim_cnt_q;
        frame_done_d = 1'b0;
        pend_clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (vsync) begin
                    if (enable) begin
                        state_d = ST_TURN;
                    end else begin
                        frame_done_d = 1'b1;
                    end
                end
            end
            ST_TURN: begin
                turned_d  = 1'b0;
                no_move_d = 1'b0;
                if (pend_valid_q) begin
                    if (pend_dir_q != dir_q) begin
                        prev_dir_d = dir_q;
                        dir_d      = pend_dir_q;
                        turned_d   = 1'b1;
                    end else begin
                        pend_clr = 1'b1;
                    end
                end
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (blocked) begin
                    // A blocked turn is undone but stays pending for a retry
                    no_move_d = 1'b1;
                    if (turned_q) begin
                        dir_d = prev_dir_q;
                    end
                end else if (turned_q) begin
                    pend_clr = 1'b1;
                end
                state_d = ST_MOVE;
            end
            default: begin
                if (no_move_q) begin
                    // Standing still shows the closed mouth
                    anim_d = 1'b1;
                end else begin
                    pos_x_d    = step_x;
                    pos_y_d    = step_y;
                    anim_d     = step_anim;
                    anim_cnt_d = step_cnt;
                end
                frame_done_d = 1'b1;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // Pending request: a new joystick strobe wins over a same-cycle clear
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_dir_d   = pend_dir_q;
        if (dirReqValid) begin
            pend_valid_d = 1'b1;
            pend_dir_d   = dirReq;
        end else if (pend_clr) begin
            pend_valid_d = 1'b0;
        end
    end

    sprite_window u_window (
        .hpos   (hpos),
        .vpos   (vpos),
        .pos_x  (pos_x_q),
        .pos_y  (pos_y_q),
        .dx     (win_dx),
        .dy     (win_dy),
        .active (win_active)
    );

    // ROM address for the current beam pixel, zero outside the sprite box
    always_comb begin
        active_d = win_active;
        xin_d    = win_active ? win_dx : 4'd0;
        yin_d    = win_active ? win_dy : 4'd0;
    end

    // Sequencer registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            dir_q        <= DIR_LEFT;
            prev_dir_q   <= DIR_LEFT;
            turned_q     <= 1'b0;
            no_move_q    <= 1'b0;
            pos_x_q      <= X_RESET;
            pos_y_q      <= Y_RESET;
            anim_q       <= 1'b0;
            anim_cnt_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            prev_dir_q   <= prev_dir_d;
            turned_q     <= turned_d;
            no_move_q    <= no_move_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            anim_q       <= anim_d;
            anim_cnt_q   <= anim_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Pending buffer registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid_q <= 1'b0;
            pend_dir_q   <= DIR_UP;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_dir_q   <= pend_dir_d;
        end
    end

    // Scan addressing registers (one cycle behind hpos/vpos)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= 1'b0;
            xin_q    <= 4'd0;
            yin_q    <= 4'd0;
        end else begin
            active_q <= active_d;
            xin_q    <= xin_d;
            yin_q    <= yin_d;
        end
    end

    assign direction    = dir_q;
    assign animState    = anim_q;
    assign posX         = pos_x_q;
    assign posY         = pos_y_q;
    assign frameDone    = frame_done_q;
    assign spriteActive = active_q;
    assign xin          = xin_q;
    assign yin          = yin_q;

endmodule

// File: tb/tb_pacman_sprite_sequencer.sv
// Directed self-checking bench for pacman_sprite_sequencer.
module tb_pacman_sprite_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       vsync;
    logic [8:0] hpos;
    logic [8:0] vpos;
    logic       enable;
    logic [1:0] dirReq;
    logic       dirReqValid;
    logic       blocked;
    logic [1:0] direction;
    logic       animState;
    logic [3:0] yin;
    logic [3:0] xin;
    logic       spriteActive;
    logic [8:0] posX;
    logic [8:0] posY;
    logic       frameDone;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         frame_no = 0;

    // Animation expectation: frames moved since last toggle, and mouth phase
    int         exp_cnt  = 0;
    logic       exp_anim = 1'b0;
    logic [1:0] dir_mid;

    always #5 clk = ~clk;

    pacman_sprite_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .vsync        (vsync),
        .hpos         (hpos),
        .vpos         (vpos),
        .enable       (enable),
        .dirReq       (dirReq),
        .dirReqValid  (dirReqValid),
        .blocked      (blocked),
        .direction    (direction),
        .animState    (animState),
        .yin          (yin),
        .xin          (xin),
        .spriteActive (spriteActive),
        .posX         (posX),
        .posY         (posY),
        .frameDone    (frameDone)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Strobe a joystick request for one cycle (called and returns at a negedge)
    task automatic request(input logic [1:0] d);
        dirReq      = d;
        dirReqValid = 1'b1;
        @(negedge clk);
        dirReqValid = 1'b0;
    endtask

    // One frame: pulse vsync, wait (bounded) for frameDone, check latency,
    // pulse width and animation phase. drop_en lowers enable after vsync.
    task automatic run_frame(input bit moves, input bit en, input bit drop_en);
        int lat;
        lat    = 0;
        enable = en;
        vsync  = 1'b1;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            vsync = 1'b0;
            if (drop_en && k == 1) enable = 1'b0;
            if (k == 2) dir_mid = direction;
            if (frameDone) lat = k;
        end
        check_eq("frame_latency", lat, en ? 4 : 1);
        if (en) begin
            if (!moves) begin
                exp_anim = 1'b1;
            end else if (exp_cnt == 7) begin
                exp_cnt  = 0;
                exp_anim = ~exp_anim;
            end else begin
                exp_cnt++;
            end
        end
        check_eq("anim_state", animState, exp_anim);
        @(negedge clk);
        check_eq("frame_done_width", frameDone, 0);
        frame_no++;
        $display("[TB] frame %0d en=%0d pos=(%0d,%0d) dir=%0d anim=%0d",
                 frame_no, en, posX, posY, direction, animState);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt;
        reset_n     = 1'b0;
        vsync       = 1'b0;
        hpos        = 9'd0;
        vpos        = 9'd0;
        enable      = 1'b1;
        dirReq      = 2'd0;
        dirReqValid = 1'b0;
        blocked     = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state
        check_eq("rst_direction", direction, 1);
        check_eq("rst_posX", posX, 112);
        check_eq("rst_posY", posY, 184);
        check_eq("rst_anim", animState, 0);
        check_eq("rst_active", spriteActive, 0);
        check_eq("rst_frame_done", frameDone, 0);
        check_eq("rst_xin", xin, 0);
        check_eq("rst_yin", yin, 0);

        // Scan addressing, one cycle behind the beam
        hpos = 9'd112; vpos = 9'd184;
        check_eq("scan_lag", spriteActive, 0);
        @(negedge clk);
        check_eq("scan_corner_active", spriteActive, 1);
        check_eq("scan_corner_xin", xin, 0);
        check_eq("scan_corner_yin", yin, 0);
        $display("[TB] scan (112,184) act=%0d xin=%0d yin=%0d", spriteActive, xin, yin);
        hpos = 9'd127; vpos = 9'd199;
        @(negedge clk);
        check_eq("scan_far_active", spriteActive, 1);
        check_eq("scan_far_xin", xin, 15);
        check_eq("scan_far_yin", yin, 15);
        $display("[TB] scan (127,199) act=%0d xin=%0d yin=%0d", spriteActive, xin, yin);
        hpos = 9'd128; vpos = 9'd184;
        @(negedge clk);
        check_eq("scan_right_edge_active", spriteActive, 0);
        $display("[TB] scan (128,184) act=%0d", spriteActive);
        hpos = 9'd120; vpos = 9'd183;
        @(negedge clk);
        check_eq("scan_above_active", spriteActive, 0);
        check_eq("scan_above_xin", xin, 0);
        check_eq("scan_above_yin", yin, 0);
        $display("[TB] scan (120,183) act=%0d xin=%0d yin=%0d", spriteActive, xin, yin);
        hpos = 9'd0; vpos = 9'd0;

        // 16 frames moving LEFT
        for (int i = 1; i <= 16; i++) begin
            run_frame(1'b1, 1'b1, 1'b0);
            if (i == 7)  check_eq("anim_f7", animState, 0);
            if (i == 8)  check_eq("anim_f8", animState, 1);
            if (i == 15) check_eq("anim_f15", animState, 1);
            if (i == 16) check_eq("anim_f16", animState, 0);
        end
        check_eq("left16_posX", posX, 96);
        check_eq("left16_posY", posY, 184);
        check_eq("left16_dir", direction, 1);

        // Turn UP into a wall: undone, no move, mouth closed, kept pending
        request(2'd0);
        blocked = 1'b1;
        run_frame(1'b0, 1'b1, 1'b0);
        check_eq("blk_turn_applied", dir_mid, 0);
        check_eq("blk_dir", direction, 1);
        check_eq("blk_posX", posX, 96);
        check_eq("blk_posY", posY, 184);
        check_eq("blk_anim", animState, 1);
        blocked = 1'b0;
        run_frame(1'b1, 1'b1, 1'b0);
        check_eq("retry_dir", direction, 0);
        check_eq("retry_posX", posX, 96);
        check_eq("retry_posY", posY, 183);

        // Back to LEFT, run to the tunnel and wrap
        request(2'd1);
        run_frame(1'b1, 1'b1, 1'b0);
        check_eq("left_turn_dir", direction, 1);
        check_eq("left_turn_posX", posX, 95);
        repeat (95) run_frame(1'b1, 1'b1, 1'b0);
        check_eq("left_edge_posX", posX, 0);
        run_frame(1'b1, 1'b1, 1'b0);
        check_eq("wrap_left_posX", posX, 255);
        request(2'd3);
        run_frame(1'b1, 1'b1, 1'b0);
        check_eq("wrap_right_dir", direction, 3);
        check_eq("wrap_right_posX", posX, 0);
        check_eq("wrap_right_posY", posY, 183);

        // Disabled frames: nothing changes, frameDone one cycle after vsync
        repeat (5) run_frame(1'b0, 1'b0, 1'b0);
        check_eq("dis_posX", posX, 0);
        check_eq("dis_posY", posY, 183);
        check_eq("dis_dir", direction, 3);

        // enable dropping after vsync does not abort the update
        run_frame(1'b1, 1'b1, 1'b1);
        check_eq("drop_en_posX", posX, 1);
        enable = 1'b1;

        // Reset during CHECK after a turn
        request(2'd0);
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        check_eq("pre_reset_turn", direction, 0);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_dir", direction, 1);
        check_eq("mid_rst_posX", posX, 112);
        check_eq("mid_rst_posY", posY, 184);
        check_eq("mid_rst_anim", animState, 0);
        check_eq("mid_rst_frame_done", frameDone, 0);
        $display("[TB] reset in CHECK dir=%0d pos=(%0d,%0d)", direction, posX, posY);
        @(negedge clk);
        reset_n  = 1'b1;
        exp_cnt  = 0;
        exp_anim = 1'b0;
        done_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (frameDone) done_cnt++;
        end
        check_eq("no_update_without_vsync", done_cnt, 0);

        // Frame with a second vsync while busy; pending must be empty
        done_cnt = 0;
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        vsync = 1'b1;
        if (frameDone) done_cnt++;
        @(negedge clk);
        vsync = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (frameDone) done_cnt++;
        end
        check_eq("busy_vsync_ignored", done_cnt, 1);
        check_eq("post_rst_dir", direction, 1);
        check_eq("post_rst_posX", posX, 111);
        check_eq("post_rst_posY", posY, 184);
        check_eq("post_rst_anim", animState, 0);
        $display("[TB] post-reset frame pos=(%0d,%0d) dir=%0d done=%0d", posX, posY, direction, done_cnt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pacman_sprite_sequencer.md
# pacman_sprite_sequencer

Frame-level controller for the Pac-Man sprite bitmap ROM. Once per frame it applies buffered joystick turns, checks maze blocking, moves the sprite and steps the chomp animation. During scan-out it generates the registered `yin`/`xin`/`spriteActive` addressing that drives the bitmap ROM. It sits between the joystick/maze logic and the bitmap ROM in the video pipeline.

## Interface
- `ANIM_PERIOD`, 8: frames per animState toggle (≥1).
- `START_X`, 112: posX after reset.
- `START_Y`, 184: posY after reset.
- `X_WRAP`, 256: horizontal tunnel width. posX ∈ [0, X_WRAP-1].
- `Y_MAX`, 224: largest legal posY.
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `vsync` in 1: one-cycle frame strobe at start of vblank.
- `hpos` in 9: current beam column.
- `vpos` in 9: current beam row.
- `enable` in 1: game running. When low, no turn, move or animation.
- `dirReq` in 2: requested direction.
- `dirReqValid` in 1: one-cycle strobe; latches `dirReq` as pending.
- `blocked` in 1: from maze logic, combinational on posX/posY/direction. Valid one cycle after they change.
- `direction` out 2: to bitmap ROM. 0=UP, 1=LEFT, 2=DOWN, 3=RIGHT.
- `animState` out 1: to bitmap ROM.
- `yin` out 4: sprite row. 0 when inactive.
- `xin` out 4: sprite column. 0 when inactive.
- `spriteActive` out 1: current pixel lies inside the 16×16 sprite box.
- `posX` out 9: sprite top-left corner, x.
- `posY` out 9: sprite top-left corner, y.
- `frameDone` out 1: one-cycle pulse when the per-frame update completes.

## Operation
- Reset values:
  - direction=LEFT(1), animState=0, posX=START_X, posY=START_Y.
  - yin=xin=0, spriteActive=0, frameDone=0.
  - pending buffer empty, animation counter 0, state IDLE.
- Pending buffer: one entry (pendValid, pendDir).
  - `dirReqValid` overwrites it in any state.
  - Write takes priority over a same-cycle clear.
- FSM states: IDLE → TURN → CHECK → MOVE → IDLE.
- IDLE: wait for `vsync`.
  - vsync with enable=0 → stay IDLE, pulse frameDone.
  - vsync with enable=1 → go to TURN.
  - vsync in any other state is ignored.
- TURN:
  - If pendValid and pendDir≠direction: save prevDir, set direction=pendDir, mark turned.
  - pendDir==direction: clear pending.
  - Go to CHECK.
- CHECK: sample `blocked`.
  - blocked and turned: restore direction=prevDir, keep pending (retry next frame), set noMove.
  - blocked and not turned: set noMove.
  - not blocked and turned: clear pending.
  - Go to MOVE.
- MOVE:
  - If !noMove, step one pixel in the current direction:
    - LEFT at posX=0 → X_WRAP-1.
    - RIGHT at X_WRAP-1 → 0.
    - UP saturates at 0.
    - DOWN saturates at Y_MAX.
  - Animation when moving: counter++. When the counter reaches ANIM_PERIOD-1, reset it to 0 and toggle animState.
  - Animation when noMove: force animState=1 (closed mouth), hold the counter.
  - Pulse frameDone. Go to IDLE.
- Scan addressing, every cycle:
  - dx = hpos−posX and dy = vpos−posY, both mod 2⁹.
  - active = (dx<16) && (dy<16).
  - Registered outputs: spriteActive=active, xin=dx[3:0], yin=dy[3:0], zeroed when inactive.
  - No on-screen wrap of the sprite box.

## Timing
- Frame update is 4 cycles after vsync: TURN at +1, CHECK at +2, MOVE at +3, frameDone high at +4.
- direction, animState and pos change only in TURN, CHECK or MOVE, so they must fall in vblank.
- Scan outputs lag hpos/vpos by exactly 1 cycle. ROM `out` is combinational on them.
- Reset asserted mid-sequence: all state returns to reset values immediately. The next update waits for a fresh vsync.
- enable falling mid-sequence: the current sequence completes. enable is sampled only at vsync.

## Structure
- Package `pacman_pkg` holds:
  - direction constants DIR_UP=0, DIR_LEFT=1, DIR_DOWN=2, DIR_RIGHT=3;
  - FSM state encoding;
  - SPRITE_SIZE=16.
- Sub-module `sprite_window` computes (dx, dy, active) from hpos/vpos and posX/posY. It is reused later for the ghost sprites.

## Test plan
- Reset, then sample: direction=1, pos=(112,184), animState=0, spriteActive=0. Beam at (112,184) → spriteActive=1, xin=yin=0 one cycle later. Beam at (127,199) → xin=yin=15. Beam at (128,184) → spriteActive=0.
- 16 frames LEFT, blocked=0: posX=96. animState toggles after frames 8 and 16. frameDone comes 4 cycles after each vsync.
- posX=0 moving LEFT: posX=255 after one frame. Moving RIGHT from 255 → 0.
- dirReq=UP with blocked=1 in CHECK: direction returns to LEFT, pos unchanged, animState=1, pending kept. Next frame blocked=0 → direction=UP, posY decrements by 1, pending cleared.
- enable=0 for 5 frames: pos, direction and animState unchanged. frameDone pulses 1 cycle after each vsync.
- reset_n asserted during CHECK after a turn: outputs at reset values the same cycle, pending empty. A vsync while not IDLE is ignored.
